// File: rtl/vec_mem_gather_scatter.sv
// Vector gather/scatter engine: one multi-address vector packet becomes per-lane scalar accesses, lane 0 first.
// Optional build macro VEC_GATHER_COALESCE_EN: a read lane whose address equals the previous lane's reuses its data.
module vec_mem_gather_scatter #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 64,
    parameter int ADDR_W    = 32,
    parameter int BUS_ID_W  = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [7:0]                    req_type,
    input  logic [BUS_ID_W-1:0]           req_source,
    input  logic [NUM_LANES*LANE_W-1:0]   req_address,
    input  logic [NUM_LANES*LANE_W-1:0]   req_payload,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [7:0]                    resp_type,
    output logic [BUS_ID_W-1:0]           resp_source,
    output logic [NUM_LANES*LANE_W-1:0]   resp_address,
    output logic [NUM_LANES*LANE_W-1:0]   resp_payload,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [LANE_W-1:0]             mem_wdata,
    input  logic                          mem_rvalid,
    input  logic [LANE_W-1:0]             mem_rdata,
    output logic                          err_illegal
);

    localparam int LANE_CW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LANE_CW-1:0] LAST_LANE = LANE_CW'(NUM_LANES - 1);

`ifdef VEC_GATHER_COALESCE_EN
    localparam bit COALESCE_EN = 1'b1;
`else
    localparam bit COALESCE_EN = 1'b0;
`endif

    localparam logic [7:0] TYPE_RD      = 8'd0;
    localparam logic [7:0] TYPE_WR      = 8'd1;
    localparam logic [7:0] TYPE_RD_RESP = 8'd2;
    localparam logic [7:0] TYPE_WR_RESP = 8'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t               state_q, state_d;
    logic [LANE_CW-1:0]   lane_q, lane_d;
    logic                 is_wr_q, is_wr_d;
    logic [BUS_ID_W-1:0]  src_q, src_d;
    logic [LANE_W-1:0]    addr_q [NUM_LANES];
    logic [LANE_W-1:0]    addr_d [NUM_LANES];
    logic [LANE_W-1:0]    data_q [NUM_LANES];
    logic [LANE_W-1:0]    data_d [NUM_LANES];

    logic                 req_ready_q, req_ready_d;
    logic                 err_illegal_q, err_illegal_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [7:0]           resp_type_q, resp_type_d;
    logic                 mem_req_valid_q, mem_req_valid_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [LANE_W-1:0]    mem_wdata_q, mem_wdata_d;

    logic                 req_is_legal;
    logic                 coalesce_now;
    logic [LANE_CW-1:0]   lane_prev;

    // A read lane repeating the previous lane's scalar address needs no memory access.
    function automatic logic coalesces(input logic is_wr, input logic [LANE_CW-1:0] lane,
                                       input logic [LANE_W-1:0] addr [NUM_LANES]);
        logic [LANE_CW-1:0] prev;
        prev = lane - 1'b1;
        return COALESCE_EN && !is_wr && (lane != '0)
               && (addr[lane][ADDR_W-1:0] == addr[prev][ADDR_W-1:0]);
    endfunction

    assign req_is_legal = (req_type == TYPE_RD) || (req_type == TYPE_WR);
    assign lane_prev    = lane_q - 1'b1;
    assign coalesce_now = (state_q == ISSUE) && coalesces(is_wr_q, lane_q, addr_q);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            is_wr_q <= 1'b0;
            src_q   <= '0;
            // NOTE: the lane buffers are a handful of flops, not a RAM, so they reset like any register.
            for (int i = 0; i < NUM_LANES; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            req_ready_q     <= 1'b0;
            err_illegal_q   <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_type_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            lane_q          <= lane_d;
            is_wr_q         <= is_wr_d;
            src_q           <= src_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            req_ready_q     <= req_ready_d;
            err_illegal_q   <= err_illegal_d;
            resp_valid_q    <= resp_valid_d;
            resp_type_q     <= resp_type_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        lane_d  = lane_q;
        is_wr_d = is_wr_q;
        src_d   = src_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q && req_is_legal) begin
                    state_d = ISSUE;
                    lane_d  = '0;
                    is_wr_d = (req_type == TYPE_WR);
                    src_d   = req_source;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        addr_d[i] = req_address[i*LANE_W +: LANE_W];
                        data_d[i] = req_payload[i*LANE_W +: LANE_W];
                    end
                end
            end
            ISSUE: begin
                if (coalesce_now) begin
                    data_d[lane_q] = data_q[lane_prev];
                    if (lane_q == LAST_LANE) state_d = RESP;
                    else lane_d = lane_q + 1'b1;
                end else if (mem_req_valid_q && mem_req_ready) begin
                    if (!is_wr_q) state_d = WAIT_RD;
                    else if (lane_q == LAST_LANE) state_d = RESP;
                    else lane_d = lane_q + 1'b1;
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    data_d[lane_q] = mem_rdata;
                    if (lane_q == LAST_LANE) begin
                        state_d = RESP;
                    end else begin
                        lane_d  = lane_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            RESP: begin
                if (resp_valid_q && resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        req_ready_d     = (state_d == IDLE);
        err_illegal_d   = (state_q == IDLE) && req_valid && req_ready_q && !req_is_legal;
        mem_req_valid_d = (state_d == ISSUE) && !coalesces(is_wr_d, lane_d, addr_d);
        mem_we_d        = mem_req_valid_d && is_wr_d;
        mem_addr_d      = mem_req_valid_d ? addr_d[lane_d][ADDR_W-1:0] : '0;
        mem_wdata_d     = mem_we_d ? data_d[lane_d] : '0;
        resp_valid_d    = (state_d == RESP);
        resp_type_d     = !resp_valid_d ? 8'd0 : (is_wr_d ? TYPE_WR_RESP : TYPE_RD_RESP);
    end

    assign req_ready     = req_ready_q;
    assign err_illegal   = err_illegal_q;
    assign resp_valid    = resp_valid_q;
    assign resp_type     = resp_type_q;
    assign resp_source   = src_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign resp_address[g*LANE_W +: LANE_W] = addr_q[g];
        assign resp_payload[g*LANE_W +: LANE_W] = data_q[g];
    end

endmodule

// File: tb/tb_vec_mem_gather_scatter.sv
// Scoreboard bench for vec_mem_gather_scatter: a word-memory model, a reference memory and a response monitor.
// Honours VEC_GATHER_COALESCE_EN the same way as the design build.
module tb_vec_mem_gather_scatter;

    localparam int NL = 4;
    localparam int LW = 64;
    localparam int AW = 32;
    localparam int BW = 8;
    localparam int PW = NL * LW;

`ifdef VEC_GATHER_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [7:0]    req_type = '0;
    logic [BW-1:0] req_source = '0;
    logic [PW-1:0] req_address = '0;
    logic [PW-1:0] req_payload = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [7:0]    resp_type;
    logic [BW-1:0] resp_source;
    logic [PW-1:0] resp_address;
    logic [PW-1:0] resp_payload;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_rvalid = 1'b0;
    logic [LW-1:0] mem_rdata = '0;
    logic          err_illegal;

    always #5 clk = ~clk;

    vec_mem_gather_scatter #(.NUM_LANES(NL), .LANE_W(LW), .ADDR_W(AW), .BUS_ID_W(BW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_source(req_source), .req_address(req_address), .req_payload(req_payload),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_type(resp_type),
        .resp_source(resp_source), .resp_address(resp_address), .resp_payload(resp_payload),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .err_illegal(err_illegal)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]    rtype;
        logic [BW-1:0] src;
        logic [PW-1:0] addr;
        logic [PW-1:0] data;
        int            lat;
        int            rstall;
    } resp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } acc_t;

    resp_t         sb_q[$];
    acc_t          acc_q[$];
    logic [LW-1:0] ref_mem [logic [AW-1:0]];
    logic [LW-1:0] ext_mem [logic [AW-1:0]];

    function automatic logic [LW-1:0] init_word(input logic [AW-1:0] a);
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    function automatic logic [LW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [LW-1:0] ext_rd(input logic [AW-1:0] a);
        return ext_mem.exists(a) ? ext_mem[a] : init_word(a);
    endfunction

    function automatic logic [PW-1:0] vec4(input logic [LW-1:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: decides mem_req_ready at each falling edge and acts on the handshake at the next rising edge.
    bit            rand_ready = 1'b0;
    int            rd_lat     = 1;
    logic [AW-1:0] stall_addr = '0;
    int            stall_left = 0;
    int            pend_cnt   = 0;
    logic [LW-1:0] pend_data  = '0;
    bit            prev_stall = 1'b0;
    acc_t          prev_acc;
    int            n_mem_rd   = 0;
    int            n_mem_wr   = 0;

    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
            end
        end
        if (!reset_n) begin
            prev_stall    = 1'b0;
            mem_req_ready = 1'b1;
        end else begin
            if (prev_stall) begin
                check("mem_stall_valid", mem_req_valid, 1'b1);
                check("mem_stall_addr", mem_addr, prev_acc.addr);
                check("mem_stall_we", mem_we, prev_acc.we);
                check("mem_stall_wdata", mem_wdata, prev_acc.wdata);
            end
            if (mem_req_valid && stall_left > 0 && mem_addr == stall_addr) begin
                mem_req_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                mem_req_ready = ($urandom_range(0, 3) != 0);
            end else begin
                mem_req_ready = 1'b1;
            end
            prev_stall = mem_req_valid && !mem_req_ready;
            prev_acc   = '{mem_we, mem_addr, mem_wdata};
            if (mem_req_valid && mem_req_ready) begin
                check("mem_access_expected", acc_q.size() != 0, 1'b1);
                if (acc_q.size() != 0) begin
                    acc_t e;
                    e = acc_q.pop_front();
                    check("mem_we", mem_we, e.we);
                    check("mem_addr", mem_addr, e.addr);
                    if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                end
                if (mem_we) begin
                    ext_mem[mem_addr] = mem_wdata;
                    n_mem_wr++;
                end else begin
                    n_mem_rd++;
                    pend_data = ext_rd(mem_addr);
                    pend_cnt  = rd_lat;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard when a response appears and compares on the handshake.
    bit            resp_seen = 1'b0;
    bit            resp_have = 1'b0;
    bit            resp_hs_prev = 1'b0;
    int            rs_left = 0;
    resp_t         cur;
    logic [7:0]    snap_type;
    logic [BW-1:0] snap_src;
    logic [PW-1:0] snap_addr, snap_data;
    int            n_resp  = 0;
    int            n_err   = 0;
    int            exp_err = 0;
    int            acc_cyc = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            resp_seen    = 1'b0;
            resp_hs_prev = 1'b0;
            resp_ready   = 1'b1;
        end else begin
            if (resp_hs_prev) check("req_ready_after_hs", req_ready, 1'b1);
            resp_hs_prev = 1'b0;
            if (err_illegal) n_err++;
            if (req_valid && req_ready) acc_cyc = cyc + 1;
            if (resp_valid) begin
                if (!resp_seen) begin
                    resp_seen = 1'b1;
                    check("resp_expected", sb_q.size() != 0, 1'b1);
                    resp_have = (sb_q.size() != 0);
                    rs_left   = 0;
                    if (resp_have) begin
                        cur     = sb_q.pop_front();
                        rs_left = cur.rstall;
                        if (cur.lat >= 0) check("resp_latency", cyc - acc_cyc + 1, cur.lat);
                    end
                end else begin
                    check("resp_hold_type", resp_type, snap_type);
                    check("resp_hold_source", resp_source, snap_src);
                    check("resp_hold_address", resp_address, snap_addr);
                    check("resp_hold_payload", resp_payload, snap_data);
                end
                snap_type = resp_type;
                snap_src  = resp_source;
                snap_addr = resp_address;
                snap_data = resp_payload;
                check("req_ready_in_resp", req_ready, 1'b0);
                resp_ready = (rs_left == 0);
                if (rs_left > 0) rs_left--;
                if (resp_ready) begin
                    if (resp_have) begin
                        check("resp_type", resp_type, cur.rtype);
                        check("resp_source", resp_source, cur.src);
                        check("resp_address", resp_address, cur.addr);
                        check("resp_payload", resp_payload, cur.data);
                    end
                    n_resp++;
                    resp_seen    = 1'b0;
                    resp_hs_prev = 1'b1;
                end
            end else begin
                resp_ready = 1'b1;
            end
        end
    end

    // Reference model: expected scalar accesses, response and latency follow from the packet alone.
    task automatic send(input logic [7:0] t, input logic [BW-1:0] src, input logic [PW-1:0] addr,
                        input logic [PW-1:0] data, input int rstall, input bit chk_lat);
        int n;
        if (t == 8'd0 || t == 8'd1) begin
            resp_t         r;
            int            lat;
            logic [AW-1:0] la, prev_la;
            lat      = 1;
            r.rtype  = (t == 8'd1) ? 8'd3 : 8'd2;
            r.src    = src;
            r.addr   = addr;
            r.data   = data;
            r.rstall = rstall;
            prev_la  = '0;
            for (int i = 0; i < NL; i++) begin
                la = addr[i*LW +: AW];
                if (t == 8'd1) begin
                    ref_mem[la] = data[i*LW +: LW];
                    acc_q.push_back('{1'b1, la, data[i*LW +: LW]});
                    lat += 1;
                end else begin
                    if (COAL && i > 0 && la == prev_la) begin
                        lat += 1;
                    end else begin
                        acc_q.push_back('{1'b0, la, '0});
                        lat += 2;
                    end
                    r.data[i*LW +: LW] = ref_rd(la);
                end
                prev_la = la;
            end
            r.lat = chk_lat ? lat : -1;
            sb_q.push_back(r);
        end else begin
            exp_err++;
        end
        req_valid   = 1'b1;
        req_type    = t;
        req_source  = src;
        req_address = addr;
        req_payload = data;
        n = 0;
        while (n < 500) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
        end
        check("req_accept_in_time", n < 500, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || acc_q.size() != 0 || resp_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_in_time", n < 3000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 1'b0);
        check({tag, "_resp_valid"}, resp_valid, 1'b0);
        check({tag, "_resp_type"}, resp_type, '0);
        check({tag, "_resp_source"}, resp_source, '0);
        check({tag, "_resp_address"}, resp_address, '0);
        check({tag, "_resp_payload"}, resp_payload, '0);
        check({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
        check({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, '0);
        check({tag, "_mem_wdata"}, mem_wdata, '0);
        check({tag, "_err_illegal"}, err_illegal, 1'b0);
    endtask

    localparam logic [LW-1:0] PA = 64'hAAAA_0000_1111_000A;
    localparam logic [LW-1:0] PB = 64'hBBBB_0000_2222_000B;
    localparam logic [LW-1:0] PC = 64'hCCCC_0000_3333_000C;
    localparam logic [LW-1:0] PD = 64'hDDDD_0000_4444_000D;

    initial begin
        int            before_err, before_mem, before_resp, before_rd, n;
        logic [PW-1:0] a, d;
        logic [LW-1:0] w;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("req_ready_after_reset", req_ready, 1'b1);

        // Scatter write, then gather the same words back in reverse lane order.
        send(8'd1, 8'd5, vec4(64'h10, 64'h18, 64'h20, 64'h28), vec4(PA, PB, PC, PD), 0, 1'b1);
        drain();
        w = ext_mem[32'h28];
        check("mem_word_0x28", w, PD);
        send(8'd0, 8'd6, vec4(64'h28, 64'h20, 64'h18, 64'h10), '0, 0, 1'b1);
        drain();

        // Memory stalls lane 2 for three cycles.
        stall_addr = 32'h20;
        stall_left = 3;
        send(8'd0, 8'd7, vec4(64'h10, 64'h18, 64'h20, 64'h28), '0, 0, 1'b0);
        drain();
        check("stall_consumed", stall_left, 0);

        // Response held for four cycles with the next packet already waiting.
        send(8'd1, 8'd8, vec4(64'h30, 64'h38, 64'h40, 64'h48), vec4(PD, PC, PB, PA), 4, 1'b0);
        send(8'd0, 8'd9, vec4(64'h48, 64'h30, 64'h38, 64'h40), '0, 0, 1'b0);
        drain();

        // Illegal request type is swallowed with a single error pulse.
        before_err  = n_err;
        before_mem  = n_mem_rd + n_mem_wr;
        before_resp = n_resp;
        send(8'd2, 8'd10, vec4(64'h10, 64'h18, 64'h20, 64'h28), '0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("illegal_err_pulses", n_err - before_err, 1);
        check("illegal_no_mem", n_mem_rd + n_mem_wr, before_mem);
        check("illegal_no_resp", n_resp, before_resp);

        // Reset while waiting on read data; the late data must not produce a response.
        rd_lat      = 6;
        before_rd   = n_mem_rd;
        before_resp = n_resp;
        send(8'd0, 8'd11, vec4(64'h10, 64'h18, 64'h20, 64'h28), '0, 0, 1'b0);
        n = 0;
        while (n_mem_rd == before_rd && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reset_test_read_issued", n < 100, 1'b1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("abort");
        sb_q.delete();
        acc_q.delete();
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_resp", n_resp, before_resp);
        rd_lat = 1;

        // Repeated lane addresses: coalesced only when the option is built in.
        before_rd = n_mem_rd;
        send(8'd0, 8'd12, vec4(64'h40, 64'h40, 64'h40, 64'h48), '0, 0, 1'b1);
        drain();
        check("dup_read_count", n_mem_rd - before_rd, COAL ? 2 : 4);

        // Randomised traffic over a small address pool so words get reused and repeated.
        rand_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            logic [7:0] t;
            rd_lat = $urandom_range(1, 3);
            for (int i = 0; i < NL; i++) begin
                a[i*LW +: LW] = {$urandom_range(0, 3) == 0 ? 32'h0 : 32'($urandom),
                                 32'h100 + 32'(8 * $urandom_range(0, 7))};
                d[i*LW +: LW] = {$urandom, $urandom};
            end
            if ($urandom_range(0, 9) == 0) t = 8'($urandom_range(2, 255));
            else t = 8'($urandom_range(0, 1));
            send(t, 8'($urandom), a, d, $urandom_range(0, 2), 1'b0);
        end
        drain();
        rand_ready = 1'b0;
        check("illegal_total", n_err, exp_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
